shift_issue_stage: RTL and testbench
====================================

// Module: shift_issue_stage
// PURPOSE
//  Execute-stage front end for pRISC shift instructions (SLL/SRL/SRA and variable forms).
//  Decodes the op, selects the shift amount (immediate shamt or rt[4:0]), and registers the operands (S1).
//  Drives the combinational barrel shifter from S1, then captures its result in an output register (S2).
//  Uses valid/ready handshakes on both sides, so stalls from writeback propagate upstream without losing data.
// PARAMETERS
//  DATA_W   32  operand/result width
//  SHAMT_W  5   shift-amount width; must equal log2(DATA_W)
//  CNT_W    16  width of completed-shift counter
// PORTS
//  clk        in   1        single clock; all state updates on posedge
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        upstream op valid
//  in_ready   out  1        stage can accept op this cycle
//  in_op      in   3        000 SLL, 001 SRL, 010 SRA, 100 SLLV, 101 SRLV, 110 SRAV; others illegal
//  in_rs      in   DATA_W   value to shift
//  in_rt      in   DATA_W   variable-amount source (low SHAMT_W bits used)
//  in_shamt   in   SHAMT_W  immediate shift amount
//  in_rd      in   5        destination register tag, passed through
//  sh_a       out  DATA_W   to shifter: operand (S1)
//  sh_shamt   out  SHAMT_W  to shifter: amount (S1)
//  sh_dir     out  1        to shifter: 0 left, 1 right
//  sh_type    out  1        to shifter: 0 logical, 1 arithmetic
//  sh_res     in   DATA_W   from shifter: combinational result of sh_* inputs
//  out_valid  out  1        result valid (S2)
//  out_ready  in   1        downstream accepts result
//  out_res    out  DATA_W   shifted result
//  out_rd     out  5        destination tag
//  out_err    out  1        op was illegal
//  shift_cnt  out  CNT_W    count of completed output transfers
// BEHAVIOUR
//  Reset: all valids, S1/S2 data, sh_*, out_*, and shift_cnt go to 0; in_ready is 1 on the first cycle after reset.
//  adv2 = out_valid & out_ready; s2_free = !out_valid | out_ready; adv1 = v1 & s2_free.
//  in_ready = !v1 | adv1 (combinational; one op per cycle sustained).
//  Accept (in_valid & in_ready):
//   - S1 loads a = in_rs.
//   - shamt = in_op[2] ? in_rt[SHAMT_W-1:0] : in_shamt.
//   - dir = (in_op[1:0] != 00); type = (in_op[1:0] == 10); rd; err = illegal.
//  Illegal op (011, 111): S1 loads shamt=0, dir=0, type=0, so out_res = in_rs, out_err=1. Otherwise the op flows normally.
//  sh_* are driven directly from the S1 registers and hold their value while S1 is stalled.
//  adv1: S2 loads out_res = sh_res plus rd/err from S1; out_valid <= 1. S1 clears v1 unless it accepts in the same cycle.
//  adv2 without adv1: out_valid <= 0.
//  Latency: accept at edge N -> out_valid after edge N+1, consumed earliest at edge N+2.
//  Backpressure: out_ready=0 with S2 full holds S2 and S1. in_ready then drops only if S1 is also valid.
//  Simultaneous accept and adv1: S1 is overwritten with the new op; no bubble.
//  shift_cnt increments on every adv2 and wraps modulo 2^CNT_W.
//  rst mid-operation: in-flight ops are discarded, no output transfer occurs, and the counter clears.
//  out_res/out_rd/out_err are stable while out_valid=1 and out_ready=0.
// CONFIGURATION
//  SHIFT_FLAGS_EN defined:
//   - adds outputs out_zero (out_res==0) and out_neg (out_res[DATA_W-1]).
//   - both are registered in S2 alongside out_res and reset to 0.
//  SHIFT_FLAGS_EN undefined: these ports and registers are absent; all other behaviour is identical.
// TESTING
//  SLL rs=0x0000_0001 shamt=31, out_ready=1 -> out_res=0x8000_0000, out_valid exactly 1 cycle after accept.
//  SRAV rs=0x8000_0000 rt=0xFFFF_FFE4 (amt 4) -> out_res=0xF800_0000. SRLV same -> 0x0800_0000.
//  Back-to-back SRL shamt 1,2,3 on rs=0xF0, out_ready=1 -> results 0x78, 0x3C, 0x1E on consecutive cycles; in_ready stays 1.
//  Stall: out_ready=0 for 5 cycles with 3 ops offered -> 2 held (S2, S1) and in_ready=0.
//   On release, results emerge in order with no loss or duplication; shift_cnt +=3 after the drain.
//  Illegal op 011, rs=0x1234_5678 -> out_res=0x1234_5678, out_err=1. The next legal op has out_err=0.
//  rst asserted while S1 and S2 are full -> next cycle out_valid=0, shift_cnt=0, in_ready=1.
//   With SHIFT_FLAGS_EN: SLL 0x1 by 31 -> out_neg=1; SRL 0x1 by 1 -> out_zero=1.

Source files
------------

// File: rtl/shift_issue_stage.sv
// shift_issue_stage: execute-stage front end for shift instructions.
//
// Two register stages. S1 captures the decoded op: operand, shift amount,
// direction, type, destination tag and illegal-op flag. S1 drives an
// external combinational barrel shifter through sh_*. S2 captures the
// shifter result together with the tag and error flag, and presents them
// downstream.
//
// Optional build macro: SHIFT_FLAGS_EN adds the registered outputs
// out_zero (result == 0) and out_neg (result MSB). When the macro is
// undefined, those ports and registers are absent.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds valid and its payload stable until that
// transfer. Ready may depend combinationally on downstream ready, but never
// on the valid of the same interface. in_ready = !v1 | adv1, so stalls
// propagate upstream without dropping or duplicating ops.
module shift_issue_stage #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_op,
    input  logic [DATA_W-1:0]  in_rs,
    input  logic [DATA_W-1:0]  in_rt,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [4:0]         in_rd,
    output logic [DATA_W-1:0]  sh_a,
    output logic [SHAMT_W-1:0] sh_shamt,
    output logic               sh_dir,
    output logic               sh_type,
    input  logic [DATA_W-1:0]  sh_res,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_res,
    output logic [4:0]         out_rd,
    output logic               out_err,
`ifdef SHIFT_FLAGS_EN
    output logic               out_zero,
    output logic               out_neg,
`endif
    output logic [CNT_W-1:0]   shift_cnt
);

    // S1 registers
    logic               v1;
    logic [DATA_W-1:0]  s1_a;
    logic [SHAMT_W-1:0] s1_shamt;
    logic               s1_dir;
    logic               s1_type;
    logic [4:0]         s1_rd;
    logic               s1_err;

    // Handshake terms
    logic adv1;
    logic adv2;
    logic s2_free;
    logic accept;

    // Decode of the incoming op
    logic               dec_illegal;
    logic [SHAMT_W-1:0] dec_shamt;
    logic               dec_dir;
    logic               dec_type;

    // Stage advance conditions and upstream ready
    always_comb begin
        adv2     = out_valid & out_ready;
        s2_free  = ~out_valid | out_ready;
        adv1     = v1 & s2_free;
        in_ready = ~v1 | adv1;
        accept   = in_valid & in_ready;
    end

    // Op decode; an illegal op becomes a zero-amount left shift so that
    // the operand passes through unchanged with the error flag set
    always_comb begin
        dec_illegal = (in_op[1:0] == 2'b11);
        dec_shamt   = in_op[2] ? in_rt[SHAMT_W-1:0] : in_shamt;
        dec_dir     = (in_op[1:0] != 2'b00);
        dec_type    = (in_op[1:0] == 2'b10);
        if (dec_illegal) begin
            dec_shamt = '0;
            dec_dir   = 1'b0;
            dec_type  = 1'b0;
        end
    end

    // S1: load on accept, otherwise drop valid when the op moves to S2
    always_ff @(posedge clk) begin
        if (rst) begin
            v1       <= 1'b0;
            s1_a     <= '0;
            s1_shamt <= '0;
            s1_dir   <= 1'b0;
            s1_type  <= 1'b0;
            s1_rd    <= '0;
            s1_err   <= 1'b0;
        end else if (accept) begin
            v1       <= 1'b1;
            s1_a     <= in_rs;
            s1_shamt <= dec_shamt;
            s1_dir   <= dec_dir;
            s1_type  <= dec_type;
            s1_rd    <= in_rd;
            s1_err   <= dec_illegal;
        end else if (adv1) begin
            v1       <= 1'b0;
        end
    end

    // Shifter inputs come straight from S1 and hold while S1 is stalled
    always_comb begin
        sh_a     = s1_a;
        sh_shamt = s1_shamt;
        sh_dir   = s1_dir;
        sh_type  = s1_type;
    end

    // S2: capture the shifter result when S1 advances, and drop valid when
    // the result is consumed and nothing replaces it
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_res   <= '0;
            out_rd    <= '0;
            out_err   <= 1'b0;
        end else if (adv1) begin
            out_valid <= 1'b1;
            out_res   <= sh_res;
            out_rd    <= s1_rd;
            out_err   <= s1_err;
        end else if (adv2) begin
            out_valid <= 1'b0;
        end
    end

`ifdef SHIFT_FLAGS_EN
    // Result flags registered alongside out_res
    always_ff @(posedge clk) begin
        if (rst) begin
            out_zero <= 1'b0;
            out_neg  <= 1'b0;
        end else if (adv1) begin
            out_zero <= (sh_res == '0);
            out_neg  <= sh_res[DATA_W-1];
        end
    end
`endif

    // Completed-transfer counter, wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_cnt <= '0;
        end else if (adv2) begin
            shift_cnt <= shift_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_shift_issue_stage.sv
// tb_shift_issue_stage: directed scoreboard bench for shift_issue_stage.
// Drivers push the hand-computed expected {err, rd, res} on every accept.
// A negedge monitor pops and compares on every output transfer, and also
// tracks shift_cnt. The bench's shifter model lives in an always_comb block.
module tb_shift_issue_stage;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;
    localparam int CNT_W   = 16;
    localparam int W       = DATA_W + 6;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         in_op;
    logic [DATA_W-1:0]  in_rs;
    logic [DATA_W-1:0]  in_rt;
    logic [SHAMT_W-1:0] in_shamt;
    logic [4:0]         in_rd;
    logic [DATA_W-1:0]  sh_a;
    logic [SHAMT_W-1:0] sh_shamt;
    logic               sh_dir;
    logic               sh_type;
    logic [DATA_W-1:0]  sh_res;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_res;
    logic [4:0]         out_rd;
    logic               out_err;
`ifdef SHIFT_FLAGS_EN
    logic               out_zero;
    logic               out_neg;
`endif
    logic [CNT_W-1:0]   shift_cnt;

    int checks;
    int failures;
    logic [W-1:0]     exp_q[$];
    logic [CNT_W-1:0] exp_cnt;

    shift_issue_stage #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs(in_rs), .in_rt(in_rt), .in_shamt(in_shamt), .in_rd(in_rd),
        .sh_a(sh_a), .sh_shamt(sh_shamt), .sh_dir(sh_dir), .sh_type(sh_type),
        .sh_res(sh_res),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
        .out_rd(out_rd), .out_err(out_err),
`ifdef SHIFT_FLAGS_EN
        .out_zero(out_zero), .out_neg(out_neg),
`endif
        .shift_cnt(shift_cnt)
    );

    // Bench-side barrel shifter
    always_comb begin
        if (!sh_dir)      sh_res = sh_a << sh_shamt;
        else if (sh_type) sh_res = $unsigned($signed(sh_a) >>> sh_shamt);
        else              sh_res = sh_a >> sh_shamt;
    end

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: shift_cnt tracking and scoreboard pops
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst) begin
            exp_cnt = '0;
        end else begin
            chk("shift_cnt", 64'(shift_cnt), 64'(exp_cnt));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got res=0x%0h rd=%0d, required no output", out_res, out_rd);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_res", 64'(out_res), 64'(e[DATA_W-1:0]));
                    chk("out_rd",  64'(out_rd),  64'(e[DATA_W+4:DATA_W]));
                    chk("out_err", 64'(out_err), 64'(e[W-1]));
`ifdef SHIFT_FLAGS_EN
                    chk("out_zero", 64'(out_zero), 64'(e[DATA_W-1:0] == '0));
                    chk("out_neg",  64'(out_neg),  64'(e[DATA_W-1]));
`endif
                end
                exp_cnt = exp_cnt + 1'b1;
            end
        end
    end

    // Present an op on the input port
    task automatic drive(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [4:0] sa, input logic [4:0] rd);
        in_op    = op;
        in_rs    = rs;
        in_rt    = rt;
        in_shamt = sa;
        in_rd    = rd;
        in_valid = 1'b1;
    endtask

    // Wait (bounded) for the presented op to be accepted; push its expectation
    task automatic wait_accept(input logic [31:0] exp_res, input logic exp_err, output int waits);
        waits = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({exp_err, in_rd, exp_res});
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            waits++;
            if (waits > 50) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, required accept", waits);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [4:0] sa, input logic [4:0] rd,
                        input logic [31:0] exp_res, input logic exp_err, output int waits);
        drive(op, rs, rt, sa, rd);
        wait_accept(exp_res, exp_err, waits);
    endtask

    // Wait (bounded) until every expected result has left the DUT
    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || out_valid) begin
            failures++;
            $display("FAIL drain_timeout: got %0d outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        int w;
        logic [CNT_W-1:0] cnt0;
        checks    = 0;
        failures  = 0;
        exp_cnt   = '0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_rs     = '0;
        in_rt     = '0;
        in_shamt  = '0;
        in_rd     = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_res",   64'(out_res),   64'd0);
        chk("rst_shift_cnt", 64'(shift_cnt), 64'd0);
        chk("rst_sh_a",      64'(sh_a),      64'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready",  64'(in_ready),  64'd1);

        // SLL 1 by 31, latency exactly one cycle after accept
        send(3'b000, 32'h0000_0001, 32'h0000_001F, 5'd31, 5'd1, 32'h8000_0000, 1'b0, w);
        chk("lat_not_yet", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("lat_valid", 64'(out_valid), 64'd1);
        drain();

        // Variable-amount ops use rt[4:0]; the immediate field is ignored
        send(3'b110, 32'h8000_0000, 32'hFFFF_FFE4, 5'd7, 5'd2, 32'hF800_0000, 1'b0, w);
        send(3'b101, 32'h8000_0000, 32'hFFFF_FFE4, 5'd7, 5'd3, 32'h0800_0000, 1'b0, w);
        send(3'b100, 32'h0000_0003, 32'h0000_0022, 5'd9, 5'd4, 32'h0000_000C, 1'b0, w);
        drain();

        // Back-to-back SRL with no stall
        send(3'b001, 32'h0000_00F0, 32'h0, 5'd1, 5'd5, 32'h0000_0078, 1'b0, w);
        send(3'b001, 32'h0000_00F0, 32'h0, 5'd2, 5'd6, 32'h0000_003C, 1'b0, w);
        chk("b2b_wait2", 64'(w), 64'd0);
        send(3'b001, 32'h0000_00F0, 32'h0, 5'd3, 5'd7, 32'h0000_001E, 1'b0, w);
        chk("b2b_wait3", 64'(w), 64'd0);
        drain();

        // Stall: two ops held in S2/S1, a third is blocked
        cnt0 = exp_cnt;
        out_ready = 1'b0;
        send(3'b000, 32'h0000_000F, 32'h0, 5'd4, 5'd8, 32'h0000_00F0, 1'b0, w);
        send(3'b001, 32'h0000_FF00, 32'h0, 5'd8, 5'd9, 32'h0000_00FF, 1'b0, w);
        drive(3'b010, 32'h8000_0001, 32'h0, 5'd1, 5'd10);
        repeat (5) begin
            @(negedge clk);
            chk("stall_in_ready",  64'(in_ready),  64'd0);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_out_res",   64'(out_res),   64'h0000_00F0);
            chk("stall_out_rd",    64'(out_rd),    64'd8);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_accept(32'hC000_0000, 1'b0, w);
        drain();
        chk("stall_cnt_plus3", 64'(shift_cnt), 64'(cnt0 + 16'd3));

        // Illegal ops pass the operand through with the error flag
        send(3'b011, 32'h1234_5678, 32'h0, 5'd9, 5'd11, 32'h1234_5678, 1'b1, w);
        send(3'b111, 32'h8765_4321, 32'h0000_0004, 5'd2, 5'd12, 32'h8765_4321, 1'b1, w);
        send(3'b010, 32'hF000_0000, 32'h0, 5'd4, 5'd13, 32'hFF00_0000, 1'b0, w);
        send(3'b001, 32'h0000_0001, 32'h0, 5'd1, 5'd14, 32'h0000_0000, 1'b0, w);
        drain();

        // Reset with both stages full
        out_ready = 1'b0;
        send(3'b000, 32'h0000_0001, 32'h0, 5'd1, 5'd15, 32'h0000_0002, 1'b0, w);
        send(3'b000, 32'h0000_0001, 32'h0, 5'd2, 5'd16, 32'h0000_0004, 1'b0, w);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_shift_cnt", 64'(shift_cnt), 64'd0);
        chk("mrst_in_ready",  64'(in_ready),  64'd1);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mrst_no_output", 64'(out_valid), 64'd0);

        // Recovery after reset
        send(3'b101, 32'hFFFF_0000, 32'h0000_0010, 5'd0, 5'd17, 32'h0000_FFFF, 1'b0, w);
        drain();
        chk("final_cnt", 64'(shift_cnt), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
